// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the split-cache pmem arbiter: line/word widths, FSM state, requester id.
// Also holds the saturating-increment helper used by the optional statistics counters.
package pmem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } pmem_arb_state;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } pmem_arb_id;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/pmem_arb_fsm.sv
// Fairness FSM: grants one cache per transfer in IDLE, ties go to the port not granted last.
// Grant is combinational in IDLE; state/op registers change on the following edge.
// Waiting requesters are held off until pmem_resp returns the FSM to IDLE.
module pmem_arb_fsm
  import pmem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic          req_d,
  input  logic          d_write,
  input  logic          pmem_resp,
  output pmem_arb_state state,
  output logic          grant_i,
  output logic          grant_d,
  output logic          op_write
);

  pmem_arb_state state_q, state_d;
  pmem_arb_id    last_grant_q, last_grant_d;
  logic          op_write_q, op_write_d;

  always_comb begin
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          grant_d = (last_grant_q == ARB_I);
          grant_i = (last_grant_q == ARB_D);
        end else begin
          grant_i = req_i;
          grant_d = req_d;
        end
        if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = ARB_I;
        end else if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = ARB_D;
          op_write_d   = d_write;  // write wins if read is also (illegally) high
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ARB_I;
      op_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
    end
  end

  assign state    = state_q;
  assign op_write = op_write_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Shares physical memory between I-cache and D-cache; optional counters under PMEM_ARB_STATS_EN.
// Command one cycle after grant; cache resp combinational with pmem_resp; one IDLE bubble between grants.
// A requester holds its request until resp; the loser of a tie waits for the current transfer.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_pmem_read,
  input  lc3b_word i_pmem_address,
  output lc3b_data i_pmem_rdata,
  output logic     i_pmem_resp,
  input  logic     d_pmem_read,
  input  logic     d_pmem_write,
  input  lc3b_word d_pmem_address,
  input  lc3b_data d_pmem_wdata,
  output lc3b_data d_pmem_rdata,
  output logic     d_pmem_resp,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_data pmem_wdata,
  input  lc3b_data pmem_rdata,
  input  logic     pmem_resp
`ifdef PMEM_ARB_STATS_EN
  ,
  output logic [15:0] i_grant_count,
  output logic [15:0] d_grant_count,
  output logic [15:0] conflict_count
`endif
);

  logic          req_i, req_d, grant_i, grant_d, op_write;
  pmem_arb_state state;
  lc3b_word      addr_q, addr_d;
  lc3b_data      wdata_q, wdata_d;

  assign req_i = i_pmem_read;
  assign req_d = d_pmem_read | d_pmem_write;

  pmem_arb_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .req_d     (req_d),
    .d_write   (d_pmem_write),
    .pmem_resp (pmem_resp),
    .state     (state),
    .grant_i   (grant_i),
    .grant_d   (grant_d),
    .op_write  (op_write)
  );

  // Latches only load on a grant, so inputs are ignored for the whole transfer.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (grant_i) begin
      addr_d = i_pmem_address;
    end else if (grant_d) begin
      addr_d  = d_pmem_address;
      wdata_d = d_pmem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !op_write);
  assign pmem_write   = (state == SERVE_D) && op_write;
  assign i_pmem_resp  = (state == SERVE_I) && pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) && pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

`ifdef PMEM_ARB_STATS_EN
  logic [15:0] i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d, conf_q, conf_d;
  logic        conflict;

  assign conflict = ((state == SERVE_I) && req_d) || ((state == SERVE_D) && req_i) ||
                    ((state == IDLE) && req_i && req_d);

  always_comb begin
    i_cnt_d = sat_inc(i_cnt_q, grant_i);
    d_cnt_d = sat_inc(d_cnt_q, grant_d);
    conf_d  = sat_inc(conf_q, conflict);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      conf_q  <= '0;
    end else begin
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
      conf_q  <= conf_d;
    end
  end

  assign i_grant_count  = i_cnt_q;
  assign d_grant_count  = d_cnt_q;
  assign conflict_count = conf_q;
`endif

endmodule
